seq_slice_subtractor: RTL

- Multi-cycle N-bit subtractor that computes diff = a - b and a borrow-out flag.
- Processes W bits per clock and carries the borrow in a register between slices.
- Complements the combinational ripple-carry adders in the arithmetic library. Used where area matters more than latency.
- Valid/ready handshake on both input and output, so it can sit between pipeline stages.

---
 rtl/seq_slice_subtractor_if.sv | 39 +++
 rtl/seq_slice_subtractor.sv | 120 ++++++++++++
 2 files changed

// File: rtl/seq_slice_subtractor_if.sv
// Operand/result bus for seq_slice_subtractor.
// Optional overflow signal present when SUB_OVERFLOW_EN is defined.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and its payload stable until that
// edge. Ready and valid never depend combinationally on each other.
interface seq_slice_subtractor_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrow;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );
`else
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
    );
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );
`endif
endinterface

// File: rtl/seq_slice_subtractor.sv
// Sequential subtractor: diff = a - b, W bits per clock, borrow carried
// between slices in a register. Optional macro SUB_OVERFLOW_EN adds a
// signed overflow flag registered alongside diff.
//
// Operands are shifted right one slice per RUN cycle so the active slice is
// always the low W bits; result slices enter diff from the top and reach
// their final positions after N/W cycles.
module seq_slice_subtractor #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_slice_subtractor_if.slave   io_bus,
    output logic [1:0]              o_dbg_state
);
    localparam int NS = N / W;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    if ((N % W) != 0 || W < 1) begin : g_bad_cfg
        $error("seq_slice_subtractor: N (%0d) must be a multiple of W (%0d)", N, W);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [CW-1:0]   r_cnt;
    logic            r_bor;
    logic [N-1:0]    r_diff;
    logic            r_borrow;
    logic [W:0]      w_sub;
    logic            w_last;
    logic [N-1:0]    w_diff_next;

    // Current slice subtraction, one bit wider to expose the borrow out.
    assign w_sub  = {1'b0, r_a[W-1:0]} - {1'b0, r_b[W-1:0]} - {{W{1'b0}}, r_bor};
    assign w_last = (r_cnt == LAST);

    if (W == N) begin : g_single
        assign w_diff_next = w_sub[W-1:0];
    end else begin : g_multi
        assign w_diff_next = {w_sub[W-1:0], r_diff[N-1:W]};
    end

    assign io_bus.in_ready  = (r_state == IDLE);
    assign io_bus.out_valid = (r_state == DONE);
    assign io_bus.diff      = r_diff;
    assign io_bus.borrow    = r_borrow;
    assign o_dbg_state      = r_state;

`ifdef SUB_OVERFLOW_EN
    logic r_ovf;
    assign io_bus.overflow = r_ovf;

    // Signed overflow: operand signs differ and result sign differs from a.
    // At the last slice r_a/r_b hold the top slice of the latched operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= (r_a[W-1] != r_b[W-1]) && (w_sub[W-1] != r_a[W-1]);
        end
    end
`endif

    // Next-state: accept in IDLE, count slices in RUN, hand off in DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (io_bus.in_valid) w_next_state = RUN;
            RUN:     if (w_last)          w_next_state = DONE;
            DONE:    if (io_bus.out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register and datapath: latch operands, process one slice per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_bor    <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (io_bus.in_valid) begin
                        r_a   <= io_bus.a;
                        r_b   <= io_bus.b;
                        r_bor <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_diff <= w_diff_next;
                    r_a    <= r_a >> W;
                    r_b    <= r_b >> W;
                    r_bor  <= w_sub[W];
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_borrow <= w_sub[W];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
